// File: rtl/sipo_deserializer_if.sv
// Serial-in / parallel-out bundle: bit strobe and serial data in, word handshake and status out.
// The master modport is the producer/consumer side, the slave modport is the deserializer.
interface sipo_deserializer_if #(
  parameter int WIDTH = 32
);
  localparam int CNT_W = $clog2(WIDTH + 2);

  logic             inb;
  logic             en;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;
  logic             parity_err;

  modport master (
    output inb, en, ready,
    input  data, valid, busy, bit_cnt, overrun, parity_err
  );

  modport slave (
    input  inb, en, ready,
    output data, valid, busy, bit_cnt, overrun, parity_err
  );
endinterface

// File: rtl/sipo_deserializer.sv
// LSB-first serial-to-parallel deserializer with a one-word holding register and sticky overrun.
// Define SIPO_PARITY_EN to append an even-parity bit to every frame and report parity_err.
module sipo_deserializer #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  sipo_deserializer_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 2);
`ifdef SIPO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] sreg_reg;
  logic [WIDTH-1:0] data_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             valid_reg;
  logic             overrun_reg;

  logic             last_bit;
  logic             shift_bit;
  logic             load_word;
  logic [WIDTH-1:0] sreg_next;
  logic [WIDTH-1:0] word_next;

  assign last_bit  = bus.en && (cnt_reg == LAST_CNT);
  assign sreg_next = {bus.inb, sreg_reg[WIDTH-1:1]};

`ifdef SIPO_PARITY_EN
  // The trailing parity bit is checked but never enters the shifter.
  localparam logic [CNT_W-1:0] PAR_CNT = CNT_W'(WIDTH);
  assign shift_bit = bus.en && (cnt_reg != PAR_CNT);
  assign word_next = sreg_reg;
`else
  assign shift_bit = bus.en;
  assign word_next = sreg_next;
`endif

  // A completed word may load if the holding register is empty or being drained this edge.
  assign load_word = last_bit && (!valid_reg || bus.ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      sreg_reg    <= '0;
      cnt_reg     <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else if (clr) begin
      state_reg   <= IDLE;
      sreg_reg    <= '0;
      cnt_reg     <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      if (shift_bit) begin
        sreg_reg <= sreg_next;
      end

      case (state_reg)
        IDLE: begin
          if (bus.en) begin
            state_reg <= SHIFT;
            cnt_reg   <= CNT_W'(1);
          end
        end
        SHIFT: begin
          if (last_bit) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (bus.en) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      endcase

      if (load_word) begin
        data_reg  <= word_next;
        valid_reg <= 1'b1;
      end else if (bus.ready) begin
        valid_reg <= 1'b0;
      end

      if (last_bit && valid_reg && !bus.ready) begin
        overrun_reg <= 1'b1;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  logic perr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_reg <= 1'b0;
    end else if (clr) begin
      perr_reg <= 1'b0;
    end else if (load_word) begin
      perr_reg <= ^{bus.inb, sreg_reg};
    end
  end

  assign bus.parity_err = perr_reg;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.data    = data_reg;
  assign bus.valid   = valid_reg;
  assign bus.busy    = (state_reg == SHIFT);
  assign bus.bit_cnt = cnt_reg;
  assign bus.overrun = overrun_reg;
endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 Parameter WIDTH, default 32: data bits per serial word; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset; asserting it clears all state immediately.
REQ-004 clr  input  1  synchronous clear; same effect as reset, applied on the next posedge.
REQ-005 inb  input  1  serial data bit, LSB first; sampled only when en=1.
REQ-006 en  input  1  bit strobe; each posedge with en=1 consumes one bit of inb.
REQ-007 data  output  WIDTH  received parallel word; valid only while valid=1.
REQ-008 valid  output  1  holding register contains an unconsumed word.
REQ-009 ready  input  1  consumer accepts data on a posedge where valid=1 and ready=1.
REQ-010 busy  output  1  a frame is partially received (FSM in SHIFT).
REQ-011 bit_cnt  output  $clog2(WIDTH+2)  bits received in the current frame.
REQ-012 overrun  output  1  sticky; a completed word was dropped because the holding register was full.
REQ-013 parity_err  output  1  parity status of the held word; qualified by valid.

Function
REQ-014 FSM states: IDLE (bit_cnt=0, busy=0) and SHIFT (busy=1).
- IDLE->SHIFT on en=1; the bit is consumed and bit_cnt becomes 1.
- SHIFT->IDLE on the edge that consumes the last bit of the frame.
- FSM holds its state when en=0; frame length is unbounded in time.
REQ-015 Shift rule on each consumed bit: sreg <= {inb, sreg[WIDTH-1:1]}.
- After WIDTH bits, sreg[0] holds the first received bit, i.e. the inverse of an LSB-first parallel-in/serial-out shifter.
REQ-016 Frame length is WIDTH bits (WIDTH+1 bits under REQ-027); bit_cnt returns to 0 on the completing edge.
REQ-017 Latency: on the completing edge, data<=word and valid<=1; valid is visible in the next cycle, one cycle after the last bit is sampled.
REQ-018 data and parity_err stay stable while valid=1 and ready=0.
- valid falls on the edge where ready=1, unless a new word loads on that same edge.
REQ-019 Completion and handshake on the same edge (valid=1, ready=1):
- the new word loads;
- valid stays 1;
- no overrun is flagged.
REQ-020 Completion while valid=1 and ready=0:
- the new word is discarded;
- data keeps the old word;
- overrun<=1.
- The shifter still restarts at IDLE, so the next frame is received normally.
REQ-021 overrun is cleared only by rst or clr; ready does not affect it.
REQ-022 A bit strobe on the completing edge's following cycle is legal: back-to-back frames are supported with no gap cycle.
REQ-023 clr has priority over en and ready in the same cycle; that cycle's bit is dropped.
REQ-024 ready with valid=0 has no effect.

Reset
REQ-025 Values during rst, and after clr:
- FSM=IDLE, sreg=0, bit_cnt=0, data=0;
- valid=0, busy=0, overrun=0, parity_err=0.
REQ-026 rst or clr mid-frame discards the partial frame; the next en=1 starts a new frame at bit 0.

Configuration
REQ-027 With macro SIPO_PARITY_EN defined:
- each frame carries one extra bit after the WIDTH data bits; that bit is not shifted into sreg;
- this bit is an even-parity bit, so the XOR of all WIDTH+1 bits is 0 for a good frame;
- parity_err loads 1 together with the word when the check fails;
- the word is still delivered.
REQ-028 Without SIPO_PARITY_EN:
- frame = WIDTH bits;
- parity_err is tied to 0;
- no parity logic is synthesized.

Verification (WIDTH=5)
REQ-029 Basic receive: rst pulse, then en=1 for 5 cycles with inb=1,0,1,0,0 and ready=0.
- data=5'b00101 and valid=1 in the cycle after the 5th bit.
- busy=1 for bits 2..5.
REQ-030 Handshake hold: word held with ready=0 for 4 cycles.
- data and valid stay stable throughout.
- After ready=1 for one edge, valid=0.
REQ-031 Overrun: word A=5'b11111 held with ready=0, then frame B=5'b01010 completes.
- data=5'b11111, overrun=1.
- A following frame 5'b00011 with ready pulsed first delivers 5'b00011; overrun stays 1.
REQ-032 Same-edge reload: valid=1 and ready=1 on the completing edge of 5'b11000.
- valid stays 1, data=5'b11000, overrun=0.
REQ-033 Mid-frame clear: 3 bits sent, then clr=1 together with en=1.
- bit_cnt=0, busy=0, and the bit sent with clr is dropped.
- The next 5 bits 1,1,1,0,0 give data=5'b00111.
- Repeat the sequence with an asynchronous rst mid-frame; the expected result is identical.
REQ-034 Parity, with SIPO_PARITY_EN defined:
- bits 1,0,0,0,0 followed by parity bit 1 give data=5'b00001, parity_err=0;
- the same data with parity bit 0 gives parity_err=1.
